a51_keystream_core: RTL

//  A5/1 keystream engine driven by the stage flags of the A5/1 stage counter.
//  - Loads the 64-bit session key and the 22-bit frame number into three majority-clocked LFSRs.
//  - Mixes the registers, then XORs one keystream bit per enabled output cycle onto a serial data stream.
//  - Encryption and decryption are the same operation.
//  - Sits directly downstream of the counter; both blocks share C, CLR and ENABLE.

---
 rtl/a51_keystream_core_pkg.sv | 60 ++++++
 rtl/a51_keystream_core_if.sv | 33 +++
 rtl/a51_keystream_core_lfsr.sv | 34 +++
 rtl/a51_keystream_core.sv | 120 ++++++++++++
 4 files changed

// File: rtl/a51_keystream_core_pkg.sv
// Shared constants, stage encoding and helpers for the A5/1 keystream core.
// Register geometry follows the standard A5/1 definition.
package a51_keystream_core_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  // Feedback taps as bit masks: R1 {18,17,16,13}, R2 {21,20}, R3 {22,21,20,7}
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

  localparam int KEY_LEN     = 64;
  localparam int FRAME_LEN   = 22;
  localparam int KSC_W       = 8;

  localparam int KEY_SEL_W   = $clog2(KEY_LEN);
  localparam int KEY_IDX_W   = $clog2(KEY_LEN + 1);
  localparam int FRAME_SEL_W = $clog2(FRAME_LEN);
  localparam int FRAME_IDX_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADK,
    ST_LOADF,
    ST_MIX,
    ST_OUT,
    ST_FIN,
    ST_ERR
  } stage_e;

  typedef struct packed {
    logic done;
    logic outstage;
    logic mix;
    logic loadf;
    logic loadk;
  } flags_t;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // More than one flag high is an error regardless of which flags they are.
  function automatic stage_e decode_stage(input flags_t f);
    if ($countones(f) > 1) return ST_ERR;
    if (f.loadk)           return ST_LOADK;
    if (f.loadf)           return ST_LOADF;
    if (f.mix)             return ST_MIX;
    if (f.outstage)        return ST_OUT;
    if (f.done)            return ST_FIN;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/a51_keystream_core_if.sv
// Stage-flag, key/frame and serial data bundle between the stage counter side
// (master) and the keystream core (slave).
interface a51_keystream_core_if;
  import a51_keystream_core_pkg::*;

  logic                 ENABLE;
  logic                 STAGEONE;
  logic                 STAGETWO;
  logic                 STAGETHREE;
  logic                 OUTPUTSTAGE;
  logic                 DONE;
  logic [KEY_LEN-1:0]   KEY;
  logic [FRAME_LEN-1:0] FRAME;
  logic                 DIN;
  logic                 DOUT;
  logic                 DVALID;
  logic [KSC_W-1:0]     KSCOUNT;
  logic                 ERR;
  logic                 FINISHED;

  modport master (
    output ENABLE, STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE,
    output KEY, FRAME, DIN,
    input  DOUT, DVALID, KSCOUNT, ERR, FINISHED
  );

  modport slave (
    input  ENABLE, STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE,
    input  KEY, FRAME, DIN,
    output DOUT, DVALID, KSCOUNT, ERR, FINISHED
  );

endinterface

// File: rtl/a51_keystream_core_lfsr.sv
// One A5/1 shift register: shifts left, new bit0 = tap parity ^ in_bit.
// msb reports the value bit LEN-1 takes after this cycle's shift.
module a51_keystream_core_lfsr #(
  parameter int                LEN      = 19,
  parameter int                CLK_BIT  = 8,
  parameter logic [LEN-1:0]    TAP_MASK = '0
) (
  input  logic           C,
  input  logic           CLR,
  input  logic           shift_en,
  input  logic           in_bit,
  output logic [LEN-1:0] state,
  output logic           clk_bit,
  output logic           msb
);

  logic feedback;

  assign feedback = ^(state & TAP_MASK);

  // NOTE: state registers use non-blocking assignment so every register in the
  // design samples pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge C) begin
    if (CLR) begin
      state <= '0;
    end else if (shift_en) begin
      state <= {state[LEN-2:0], feedback ^ in_bit};
    end
  end

  assign clk_bit = state[CLK_BIT];
  assign msb     = shift_en ? state[LEN-2] : state[LEN-1];

endmodule

// File: rtl/a51_keystream_core.sv
// A5/1 keystream core: decodes the counter's stage flags, loads key and frame,
// majority-clocks three LFSRs and XORs one keystream bit onto DIN per output cycle.
module a51_keystream_core
  import a51_keystream_core_pkg::*;
(
  input  logic                 C,
  input  logic                 CLR,
  a51_keystream_core_if.slave  bus
);

  flags_t                 flags;
  stage_e                 stage;
  logic [KEY_IDX_W-1:0]   key_idx;
  logic [FRAME_IDX_W-1:0] frame_idx;
  logic [2:0]             shift;
  logic                   in_bit;
  logic                   maj;
  logic                   ks;

  logic                   r1_clk, r2_clk, r3_clk;
  logic                   r1_msb, r2_msb, r3_msb;
  logic [R1_LEN-1:0]      r1_state;
  logic [R2_LEN-1:0]      r2_state;
  logic [R3_LEN-1:0]      r3_state;

  assign flags = '{done:     bus.DONE,
                   outstage: bus.OUTPUTSTAGE,
                   mix:      bus.STAGETHREE,
                   loadf:    bus.STAGETWO,
                   loadk:    bus.STAGEONE};

  assign stage = decode_stage(flags);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    shift  = 3'b000;
    in_bit = 1'b0;
    maj    = majority(r1_clk, r2_clk, r3_clk);
    if (bus.ENABLE) begin
      case (stage)
        ST_LOADK: begin
          if (key_idx < KEY_IDX_W'(KEY_LEN)) begin
            shift  = 3'b111;
            in_bit = bus.KEY[key_idx[KEY_SEL_W-1:0]];
          end
        end
        ST_LOADF: begin
          if (frame_idx < FRAME_IDX_W'(FRAME_LEN)) begin
            shift  = 3'b111;
            in_bit = bus.FRAME[frame_idx[FRAME_SEL_W-1:0]];
          end
        end
        ST_MIX, ST_OUT: begin
          shift = {r3_clk == maj, r2_clk == maj, r1_clk == maj};
        end
        default: ;
      endcase
    end
  end

  a51_keystream_core_lfsr #(
    .LEN(R1_LEN), .CLK_BIT(R1_CLK), .TAP_MASK(R1_TAPS)
  ) u_r1 (
    .C(C), .CLR(CLR), .shift_en(shift[0]), .in_bit(in_bit),
    .state(r1_state), .clk_bit(r1_clk), .msb(r1_msb)
  );

  a51_keystream_core_lfsr #(
    .LEN(R2_LEN), .CLK_BIT(R2_CLK), .TAP_MASK(R2_TAPS)
  ) u_r2 (
    .C(C), .CLR(CLR), .shift_en(shift[1]), .in_bit(in_bit),
    .state(r2_state), .clk_bit(r2_clk), .msb(r2_msb)
  );

  a51_keystream_core_lfsr #(
    .LEN(R3_LEN), .CLK_BIT(R3_CLK), .TAP_MASK(R3_TAPS)
  ) u_r3 (
    .C(C), .CLR(CLR), .shift_en(shift[2]), .in_bit(in_bit),
    .state(r3_state), .clk_bit(r3_clk), .msb(r3_msb)
  );

  // Full register contents stay visible for debug; the datapath only needs the
  // clock and post-shift msb bits.
  logic unused_state;
  assign unused_state = ^{r1_state, r2_state, r3_state};

  assign ks = r1_msb ^ r2_msb ^ r3_msb;

  // NOTE: CLR is synchronous, so it is an ordinary priority branch inside the
  // clocked block rather than part of the sensitivity list.
  always_ff @(posedge C) begin
    if (CLR) begin
      key_idx      <= '0;
      frame_idx    <= '0;
      bus.DOUT     <= 1'b0;
      bus.DVALID   <= 1'b0;
      bus.KSCOUNT  <= '0;
      bus.ERR      <= 1'b0;
      bus.FINISHED <= 1'b0;
    end else begin
      bus.DVALID <= 1'b0;
      if (bus.DONE) bus.FINISHED <= 1'b1;
      if (bus.ENABLE) begin
        case (stage)
          ST_LOADK: if (shift[0]) key_idx   <= key_idx + KEY_IDX_W'(1);
          ST_LOADF: if (shift[0]) frame_idx <= frame_idx + FRAME_IDX_W'(1);
          ST_OUT: begin
            bus.DOUT   <= bus.DIN ^ ks;
            bus.DVALID <= 1'b1;
            if (bus.KSCOUNT != '1) bus.KSCOUNT <= bus.KSCOUNT + KSC_W'(1);
          end
          ST_ERR:   bus.ERR <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
